// File: rtl/ram_byte_master_pkg.sv
// Shared definitions for the byte-wide RAM initiator: access sizes, FSM states
// and the request legality check.
package ram_byte_master_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   // Reserved size, or a half/word whose address is not naturally aligned.
   function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr_lo[0];
         SZ_W:    bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [1:0] last_byte(input logic [1:0] size);
      logic [1:0] idx;
      case (size)
         SZ_B:    idx = 2'd0;
         SZ_H:    idx = 2'd1;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/ram_byte_master_load_extend.sv
// Sign/zero extension of an assembled little-endian load result.
module load_extend
   import ram_byte_master_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] raw,
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   output logic [XLEN-1:0] result
);

   logic fill_b;
   logic fill_h;

   always_comb begin
      fill_b = raw[7] & ~is_unsigned;
      fill_h = raw[15] & ~is_unsigned;
      case (size)
         SZ_B:    result = {{(XLEN-8){fill_b}}, raw[7:0]};
         SZ_H:    result = {{(XLEN-16){fill_h}}, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/ram_byte_master.sv
// LSU-facing initiator that splits 8/16/32-bit loads and stores into
// sequential byte accesses on a single-port byte RAM.
module ram_byte_master
   import ram_byte_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int XLEN       = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [XLEN-1:0]       i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [XLEN-1:0]       o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

   state_t          state;
   logic            we_q;
   logic [1:0]      size_q;
   logic            unsigned_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] assembly_q;
   logic [1:0]      byte_cnt;

   logic [1:0]      byte_cnt_next;
   logic [XLEN-1:0] assembly_next;
   logic [XLEN-1:0] extended;

   // The byte arriving this cycle is merged before extension so the final
   // byte of a load reaches the response register on the same edge.
   always_comb begin
      byte_cnt_next = byte_cnt + 2'd1;
      assembly_next = assembly_q;
      assembly_next[{byte_cnt, 3'b000} +: 8] = i_ram_rdata;
   end

   load_extend #(
      .XLEN(XLEN)
   ) u_load_extend (
      .raw        (assembly_next),
      .size       (size_q),
      .is_unsigned(unsigned_q),
      .result     (extended)
   );

   // o_ram_addr itself serves as the running byte address, so the first
   // RAM cycle is set up directly on the accept edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         o_req_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_err   <= 1'b0;
         o_rsp_rdata <= '0;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
         we_q        <= 1'b0;
         size_q      <= SZ_B;
         unsigned_q  <= 1'b0;
         wdata_q     <= '0;
         assembly_q  <= '0;
         byte_cnt    <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  we_q        <= i_req_we;
                  size_q      <= i_req_size;
                  unsigned_q  <= i_req_unsigned;
                  wdata_q     <= i_req_wdata;
                  assembly_q  <= '0;
                  byte_cnt    <= 2'd0;
                  o_req_ready <= 1'b0;
                  if (req_is_bad(i_req_size, i_req_addr[1:0])) begin
                     state       <= ST_RESP;
                     o_rsp_valid <= 1'b1;
                     o_rsp_err   <= 1'b1;
                     o_rsp_rdata <= '0;
                  end else begin
                     state       <= ST_ACCESS;
                     o_ram_we    <= i_req_we;
                     o_ram_addr  <= i_req_addr;
                     o_ram_wdata <= i_req_wdata[7:0];
                  end
               end
            end
            ST_ACCESS: begin
               assembly_q <= assembly_next;
               if (byte_cnt == last_byte(size_q)) begin
                  state       <= ST_RESP;
                  o_ram_we    <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= 1'b0;
                  o_rsp_rdata <= we_q ? '0 : extended;
               end else begin
                  byte_cnt    <= byte_cnt_next;
                  o_ram_addr  <= o_ram_addr + ADDR_WIDTH'(1);
                  o_ram_wdata <= wdata_q[{byte_cnt_next, 3'b000} +: 8];
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  state       <= ST_IDLE;
                  o_rsp_valid <= 1'b0;
                  o_rsp_err   <= 1'b0;
                  o_rsp_rdata <= '0;
                  o_req_ready <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               o_req_ready <= 1'b1;
               o_rsp_valid <= 1'b0;
               o_ram_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_byte_master.sv
// Self-checking bench for ram_byte_master: behavioural RAM plus a
// transaction-level reference model compared against the DUT every cycle.
module tb_ram_byte_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   ram_byte_master #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(8),
      .XLEN(32)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_we      (req_we),
      .i_req_size    (req_size),
      .i_req_unsigned(req_unsigned),
      .i_req_addr    (req_addr),
      .i_req_wdata   (req_wdata),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_rdata   (rsp_rdata),
      .o_rsp_err     (rsp_err),
      .o_ram_we      (ram_we),
      .o_ram_addr    (ram_addr),
      .o_ram_wdata   (ram_wdata),
      .i_ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   // Byte RAM with combinational read and write on the clock edge.
   always_comb ram_rdata = mem[ram_addr];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction model: a request costs N byte cycles (none if illegal),
   // then a response that lasts until accepted.
   bit          m_idle = 1'b1;
   int          m_n = 0;
   int          m_cyc = 0;
   logic [15:0] m_base = '0;
   bit          m_we = 1'b0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata = '0;
   bit          m_err = 1'b0;
   int          m_bytes;
   logic [31:0] m_val;
   logic [15:0] m_addr_k;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle = 1'b1;
         m_cyc  = 0;
      end else if (m_idle) begin
         if (req_valid) begin
            m_bytes = 1 << req_size;
            m_err   = (req_size == 2'b11) || ((int'(req_addr) % m_bytes) != 0);
            m_n     = m_err ? 0 : m_bytes;
            m_base  = req_addr;
            m_we    = req_we;
            m_wdata = req_wdata;
            m_val   = 32'h0;
            if (!m_err && !req_we) begin
               for (int i = 0; i < m_n; i++)
                  m_val = m_val | (32'(ref_mem[16'(req_addr + 16'(i))]) << (8 * i));
               if (req_size == 2'b00 && !req_unsigned && m_val[7])  m_val = m_val | 32'hFFFF_FF00;
               if (req_size == 2'b01 && !req_unsigned && m_val[15]) m_val = m_val | 32'hFFFF_0000;
            end
            m_rdata = m_val;
            m_idle  = 1'b0;
            m_cyc   = 1;
         end
      end else if (m_cyc <= m_n) begin
         if (m_we) begin
            m_addr_k = m_base + 16'(m_cyc - 1);
            ref_mem[m_addr_k] = 8'((m_wdata >> (8 * (m_cyc - 1))) & 32'hFF);
         end
         m_cyc++;
      end else if (rsp_ready) begin
         m_idle = 1'b1;
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
         checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("reset_rsp_err",   32'(rsp_err),   32'd0);
         checkOutput("reset_rsp_rdata", rsp_rdata,      32'd0);
         checkOutput("reset_ram_we",    32'(ram_we),    32'd0);
         checkOutput("reset_ram_addr",  32'(ram_addr),  32'd0);
         checkOutput("reset_ram_wdata", 32'(ram_wdata), 32'd0);
      end else if (m_idle) begin
         checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
         checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("idle_ram_we",    32'(ram_we),    32'd0);
      end else if (m_cyc <= m_n) begin
         checkOutput("acc_req_ready", 32'(req_ready), 32'd0);
         checkOutput("acc_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("acc_ram_we",    32'(ram_we),    32'(m_we));
         checkOutput("acc_ram_addr",  32'(ram_addr),  32'(16'(m_base + 16'(m_cyc - 1))));
         if (m_we)
            checkOutput("acc_ram_wdata", 32'(ram_wdata), (m_wdata >> (8 * (m_cyc - 1))) & 32'hFF);
      end else begin
         checkOutput("rsp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("rsp_valid",     32'(rsp_valid), 32'd1);
         checkOutput("rsp_ram_we",    32'(ram_we),    32'd0);
         checkOutput("rsp_rdata",     rsp_rdata,      m_rdata);
         checkOutput("rsp_err",       32'(rsp_err),   32'(m_err));
      end
   end

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [15:0] addr, input logic [31:0] wdata, input int stall,
                                output logic [31:0] rdata, output logic err, output int lat);
      int guard;
      guard = 0;
      rdata = '0;
      err   = 1'b0;
      lat   = 0;
      while (!req_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!req_ready) begin
         checkOutput("wait_req_ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = $urandom;
      forever begin
         @(negedge clk);
         lat++;
         if (rsp_valid || lat > 20) break;
      end
      if (!rsp_valid) begin
         checkOutput("wait_rsp_valid_timeout", 32'(rsp_valid), 32'd1);
         return;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lt;
   logic [1:0]  rsize;
   logic [15:0] raddr;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      for (int i = 16'h0100; i < 16'h0140; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'hFFFE] = 8'h5A; ref_mem[16'hFFFE] = 8'h5A;
      mem[16'hFFFF] = 8'hA5; ref_mem[16'hFFFF] = 8'hA5;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 0, rd, er, lt);
      checkOutput("sw_latency", 32'(lt), 32'd5);
      checkOutput("sw_err", 32'(er), 32'd0);
      checkOutput("sw_mem10_13", {mem[16'h0013], mem[16'h0012], mem[16'h0011], mem[16'h0010]}, 32'hDEADBEEF);

      applyStimulus(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 0, rd, er, lt);
      checkOutput("lw_rdata", rd, 32'hDEADBEEF);
      applyStimulus(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, 1, rd, er, lt);
      checkOutput("lh_rdata", rd, 32'hFFFFDEAD);
      checkOutput("lh_latency", 32'(lt), 32'd3);
      applyStimulus(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 0, rd, er, lt);
      checkOutput("lhu_rdata", rd, 32'h0000DEAD);

      applyStimulus(1'b1, 2'b00, 1'b0, 16'h0020, 32'h12345680, 0, rd, er, lt);
      checkOutput("sb_latency", 32'(lt), 32'd2);
      checkOutput("sb_mem20_21", {16'h0, mem[16'h0021], mem[16'h0020]}, 32'h0000_0080);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h0020, 32'h0, 0, rd, er, lt);
      checkOutput("lb_rdata", rd, 32'hFFFFFF80);
      checkOutput("lb_latency", 32'(lt), 32'd2);
      applyStimulus(1'b0, 2'b00, 1'b1, 16'h0020, 32'h0, 0, rd, er, lt);
      checkOutput("lbu_rdata", rd, 32'h00000080);

      applyStimulus(1'b0, 2'b10, 1'b0, 16'h0011, 32'h0, 0, rd, er, lt);
      checkOutput("lw_misaligned_err", 32'(er), 32'd1);
      checkOutput("lw_misaligned_rdata", rd, 32'h0);
      checkOutput("lw_misaligned_latency", 32'(lt), 32'd1);
      applyStimulus(1'b1, 2'b11, 1'b0, 16'h0000, 32'hFFFFFFFF, 0, rd, er, lt);
      checkOutput("reserved_err", 32'(er), 32'd1);
      checkOutput("reserved_latency", 32'(lt), 32'd1);
      checkOutput("reserved_mem0", 32'(mem[16'h0000]), 32'h0);

      applyStimulus(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 3, rd, er, lt);
      checkOutput("stall_lw_rdata", rd, 32'hDEADBEEF);

      for (int t = 0; t < 200; t++) begin
         rsize = 2'($urandom_range(0, 3));
         raddr = 16'h0100 + 16'($urandom_range(0, 60));
         if ($urandom_range(0, 3) != 0) raddr = raddr & ~16'(((1 << rsize) - 1) & 3);
         applyStimulus(1'($urandom), rsize, 1'($urandom), raddr, $urandom,
                       $urandom_range(0, 2), rd, er, lt);
      end

      applyStimulus(1'b0, 2'b00, 1'b0, 16'h0000, 32'h0, 0, rd, er, lt);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 16'hFFFC;
      req_wdata = 32'h11223344;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("abort_mem_fffc", 32'(mem[16'hFFFC]), 32'h44);
      checkOutput("abort_mem_fffd", 32'(mem[16'hFFFD]), 32'h33);
      checkOutput("abort_mem_fffe", 32'(mem[16'hFFFE]), 32'h5A);
      checkOutput("abort_mem_ffff", 32'(mem[16'hFFFF]), 32'hA5);
      checkOutput("abort_ram_addr", 32'(ram_addr), 32'h0);
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'h0);

      applyStimulus(1'b0, 2'b01, 1'b1, 16'hFFFC, 32'h0, 0, rd, er, lt);
      checkOutput("post_abort_lhu", rd, 32'h00003344);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
